// File: rtl/audio_multi_oscillator.sv
// ---------------------------------------------------------------------------
// audio_multi_oscillator
//
// This module runs NUM_VOICES phase-accumulator oscillators. Their samples are
// time-multiplexed, one voice after another in fixed round-robin order, onto a
// single AXI-Stream style output. tuser carries the voice index of each
// sample. tlast marks the last voice of each frame. Each voice produces a
// saw, square, triangle or silence waveform. Its divisor, duty and waveform
// can be set at runtime, and its phase can be reset on demand. The waveforms
// are naive (not band-limited), so the stream is meant to be oversampled and
// filtered by the downstream mixer/decimation chain.
//
// Ports
//   clk            clock
//   reset_n        synchronous active-low reset
//   cfg_we         write the config of voice cfg_voice on this edge
//   cfg_voice      target voice of a config write (out-of-range ignored)
//   cfg_divisor    phase increment per sample for that voice
//   cfg_duty       square-wave high fraction, duty / 2^DUTY_WIDTH
//   cfg_waveform   0 saw, 1 square, 2 triangle, 3 silence
//   cfg_phase_rst  together with cfg_we, zero that voice's phase
//   tvalid         sample valid (held high from the first cycle after reset)
//   tdata          signed two's-complement sample
//   tuser          voice index of tdata
//   tlast          high when tuser is the last voice
//   tready         downstream ready
// ---------------------------------------------------------------------------
module audio_multi_oscillator #(
    parameter int SAMPLE_SIZE = 16,
    parameter int NUM_VOICES  = 4,
    parameter int PHASE_WIDTH = 32,
    parameter int DUTY_WIDTH  = 8,
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cfg_we,
    input  logic [VW-1:0]          cfg_voice,
    input  logic [PHASE_WIDTH-1:0] cfg_divisor,
    input  logic [DUTY_WIDTH-1:0]  cfg_duty,
    input  logic [1:0]             cfg_waveform,
    input  logic                   cfg_phase_rst,
    output logic                   tvalid,
    output logic [SAMPLE_SIZE-1:0] tdata,
    output logic [VW-1:0]          tuser,
    output logic                   tlast,
    input  logic                   tready
);

    typedef enum logic [1:0] {
        WAVE_SAW     = 2'd0,
        WAVE_SQUARE  = 2'd1,
        WAVE_TRI     = 2'd2,
        WAVE_SILENCE = 2'd3
    } wave_e;

    localparam logic [VW-1:0]         LAST_VOICE   = VW'(NUM_VOICES - 1);
    localparam logic [DUTY_WIDTH-1:0] DEFAULT_DUTY = {1'b1, {(DUTY_WIDTH-1){1'b0}}};

    // Maps one voice's phase and config to its output sample. For saw and
    // triangle, the top bit is inverted. This turns an unsigned ramp into a
    // signed one centred on zero.
    function automatic logic [SAMPLE_SIZE-1:0] voiceSample(
        input logic [PHASE_WIDTH-1:0] phase,
        input logic [DUTY_WIDTH-1:0]  duty,
        input wave_e                  wave
    );
        logic [SAMPLE_SIZE-1:0] p;
        logic [SAMPLE_SIZE-1:0] t;
        logic [SAMPLE_SIZE-1:0] u;
        logic [SAMPLE_SIZE-1:0] s;
        p = phase[PHASE_WIDTH-1 -: SAMPLE_SIZE];
        // The triangle uses one phase bit below the saw's range. The phase
        // MSB selects the rising or falling half.
        t = phase[PHASE_WIDTH-2 -: SAMPLE_SIZE];
        u = phase[PHASE_WIDTH-1] ? ~t : t;
        case (wave)
            WAVE_SAW:    s = {~p[SAMPLE_SIZE-1], p[SAMPLE_SIZE-2:0]};
            WAVE_SQUARE: s = (phase[PHASE_WIDTH-1 -: DUTY_WIDTH] < duty)
                             ? {1'b0, {(SAMPLE_SIZE-1){1'b1}}}
                             : {1'b1, {(SAMPLE_SIZE-1){1'b0}}};
            WAVE_TRI:    s = {~u[SAMPLE_SIZE-1], u[SAMPLE_SIZE-2:0]};
            default:     s = '0;
        endcase
        return s;
    endfunction

    logic [PHASE_WIDTH-1:0] phase_q   [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] phase_d   [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] divisor_q [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] divisor_d [NUM_VOICES];
    logic [DUTY_WIDTH-1:0]  duty_q    [NUM_VOICES];
    logic [DUTY_WIDTH-1:0]  duty_d    [NUM_VOICES];
    wave_e                  wave_q    [NUM_VOICES];
    wave_e                  wave_d    [NUM_VOICES];

    logic [VW-1:0]          curVoice_q, curVoice_d;
    logic                   tvalid_q, tvalid_d;
    logic [SAMPLE_SIZE-1:0] tdata_q, tdata_d;
    logic [VW-1:0]          tuser_q, tuser_d;
    logic                   tlast_q, tlast_d;

    logic [VW-1:0]          nextVoice;
    logic [PHASE_WIDTH-1:0] nextPhase;
    logic                   xfer;
    logic                   cfgHit;

    // Next-state logic. The order of assignments matters. First, the stream
    // handshake advances the presented voice using its old divisor. It also
    // precomputes the following voice's sample from that voice's current
    // config. Then a config write lands on top. As a result, a phase reset
    // on the same edge as an advance wins. New waveform and duty settings
    // only show up from that voice's next sample onwards.
    always_comb begin
        phase_d    = phase_q;
        divisor_d  = divisor_q;
        duty_d     = duty_q;
        wave_d     = wave_q;
        curVoice_d = curVoice_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tuser_d    = tuser_q;
        tlast_d    = tlast_q;
        nextPhase  = '0;

        xfer      = tvalid_q & tready;
        nextVoice = (curVoice_q == LAST_VOICE) ? '0 : curVoice_q + 1'b1;
        cfgHit    = cfg_we && (int'(cfg_voice) < NUM_VOICES);

        if (!tvalid_q) begin
            tvalid_d   = 1'b1;
            curVoice_d = '0;
            tuser_d    = '0;
            tlast_d    = (LAST_VOICE == '0);
            tdata_d    = voiceSample(phase_q[0], duty_q[0], wave_q[0]);
        end else if (xfer) begin
            phase_d[curVoice_q] = phase_q[curVoice_q] + divisor_q[curVoice_q];
            // With a single voice, the next voice is the one just advanced,
            // so its fresh phase is used.
            nextPhase  = (nextVoice == curVoice_q) ? phase_d[curVoice_q]
                                                   : phase_q[nextVoice];
            curVoice_d = nextVoice;
            tuser_d    = nextVoice;
            tlast_d    = (nextVoice == LAST_VOICE);
            tdata_d    = voiceSample(nextPhase, duty_q[nextVoice], wave_q[nextVoice]);
        end

        if (cfgHit) begin
            divisor_d[cfg_voice] = cfg_divisor;
            duty_d[cfg_voice]    = cfg_duty;
            wave_d[cfg_voice]    = wave_e'(cfg_waveform);
            if (cfg_phase_rst) begin
                phase_d[cfg_voice] = '0;
            end
        end
    end

    // State registers. Reset overrides everything, including a stalled
    // transfer in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i]   <= '0;
                divisor_q[i] <= '0;
                duty_q[i]    <= DEFAULT_DUTY;
                wave_q[i]    <= WAVE_SAW;
            end
            curVoice_q <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tuser_q    <= '0;
            tlast_q    <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            divisor_q  <= divisor_d;
            duty_q     <= duty_d;
            wave_q     <= wave_d;
            curVoice_q <= curVoice_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tuser_q    <= tuser_d;
            tlast_q    <= tlast_d;
        end
    end

    assign tvalid = tvalid_q;
    assign tdata  = tdata_q;
    assign tuser  = tuser_q;
    assign tlast  = tlast_q;

endmodule
